demux32three_stream: RTL and testbench

- Registered 1:3 demultiplexer for 32-bit ALU result words; the inverse of the 3:1 operand select in the ALU32 datapath.
- Accepts {sel, data} on a valid/ready input, buffers it in a small in-order FIFO, and presents each word to exactly one of three valid/ready destinations (regfile writeback, memory store path, debug/trace).
- Illegal select code 3 is consumed and flagged, never forwarded.

---
 rtl/demux32_pkg.sv | 20 ++
 rtl/fifo32_sync.sv | 54 +++++
 rtl/demux32three_stream.sv | 84 ++++++++
 tb/tb_demux32three_stream.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/demux32_pkg.sv
// Shared select codes, entry layout and select legality check for the 1:3 result demux.
package demux32_pkg;

   localparam int DEMUX_DW = 32;

   localparam logic [1:0] SEL_DST0    = 2'd0;
   localparam logic [1:0] SEL_DST1    = 2'd1;
   localparam logic [1:0] SEL_DST2    = 2'd2;
   localparam logic [1:0] SEL_ILLEGAL = 2'd3;

   typedef struct packed {
      logic [1:0]          sel;
      logic [DEMUX_DW-1:0] data;
   } demux_entry_t;

   function automatic logic is_legal_sel(input logic [1:0] sel);
      return sel != SEL_ILLEGAL;
   endfunction

endpackage

// File: rtl/fifo32_sync.sv
// Generic single-clock FIFO; head entry is shown combinationally from storage, empty shows the last popped word.
module fifo32_sync #(
   parameter int DEPTH = 2,
   parameter int W     = 34
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [W-1:0]  last_pop;

   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);
   assign head  = empty ? last_pop : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Power-of-two depth lets pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         last_pop <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            last_pop <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/demux32three_stream.sv
// Registered 1:3 demux of ALU result words through an in-order FIFO; illegal select 3 is dropped and flagged.
// Optional DEMUX32_DROP_CNT_EN adds a saturating count of dropped illegal words.
module demux32three_stream
   import demux32_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int DW    = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 in_sel,
   input  logic [DW-1:0]              in_data,
   output logic [DW-1:0]              out_data,
   output logic                       out0_valid,
   input  logic                       out0_ready,
   output logic                       out1_valid,
   input  logic                       out1_ready,
   output logic                       out2_valid,
   input  logic                       out2_ready,
   output logic                       err_sel,
`ifdef DEMUX32_DROP_CNT_EN
   output logic [7:0]                 drop_cnt,
`endif
   output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high;
   // once a valid is raised it and its data hold until that transfer, and ready never
   // depends combinationally on the same cycle's valid or select.
   logic          accept;
   logic          legal;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [DW+1:0] head;
   logic [1:0]    head_sel;

   assign legal    = is_legal_sel(in_sel);
   assign in_ready = !full;
   assign accept   = in_valid && in_ready;
   assign push     = accept && legal;

   fifo32_sync #(
      .DEPTH (DEPTH),
      .W     (DW + 2)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({in_sel, in_data}),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (fifo_level)
   );

   assign head_sel   = head[DW+1:DW];
   assign out_data   = head[DW-1:0];
   assign out0_valid = !empty && (head_sel == SEL_DST0);
   assign out1_valid = !empty && (head_sel == SEL_DST1);
   assign out2_valid = !empty && (head_sel == SEL_DST2);

   // Only the destination owning the head word can pop it.
   assign pop = (out0_valid && out0_ready) ||
                (out1_valid && out1_ready) ||
                (out2_valid && out2_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_sel <= 1'b0;
      else       err_sel <= accept && !legal;
   end

`ifdef DEMUX32_DROP_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                    drop_cnt <= 8'd0;
      else if (accept && !legal && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_demux32three_stream.sv
// Directed bench for demux32three_stream with immediate assertions at each checkpoint.
module tb_demux32three_stream;

   localparam int DEPTH = 2;
   localparam int DW    = 32;
   localparam int LW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_sel = 2'd0;
   logic [DW-1:0] in_data = '0;
   logic [DW-1:0] out_data;
   logic          out0_valid, out1_valid, out2_valid;
   logic          out0_ready = 1'b0, out1_ready = 1'b0, out2_ready = 1'b0;
   logic          err_sel;
   logic [LW-1:0] fifo_level;
`ifdef DEMUX32_DROP_CNT_EN
   logic [7:0]    drop_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   demux32three_stream #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sel     (in_sel),
      .in_data    (in_data),
      .out_data   (out_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .out2_valid (out2_valid),
      .out2_ready (out2_ready),
      .err_sel    (err_sel),
`ifdef DEMUX32_DROP_CNT_EN
      .drop_cnt   (drop_cnt),
`endif
      .fifo_level (fifo_level)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_valids(input string tag, input logic [2:0] exp);
      check(tag, {29'd0, out2_valid, out1_valid, out0_valid}, {29'd0, exp});
   endtask

   task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
   endtask

   initial begin
      // Reset and idle
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check_valids("rst_valids", 3'b000);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_err", 32'(err_sel), 32'd0);
      check("rst_data", out_data, 32'd0);

      // Single word to destination 1
      out1_ready = 1'b1;
      drive(1'b1, 2'd1, 32'hDEADBEEF);
      tick();
      drive(1'b0, 2'd0, 32'h0);
      check_valids("one_valids", 3'b010);
      check("one_data", out_data, 32'hDEADBEEF);
      check("one_level", 32'(fifo_level), 32'd1);
      tick();
      check_valids("one_after_valids", 3'b000);
      check("one_after_level", 32'(fifo_level), 32'd0);
      check("one_hold_data", out_data, 32'hDEADBEEF);
      out1_ready = 1'b0;

      // Fill with readies low, then drain in order
      drive(1'b1, 2'd0, 32'h1);
      tick();
      check("fill1_level", 32'(fifo_level), 32'd1);
      check("fill1_ready", 32'(in_ready), 32'd1);
      drive(1'b1, 2'd2, 32'h2);
      tick();
      check("fill2_level", 32'(fifo_level), 32'd2);
      check("fill2_ready", 32'(in_ready), 32'd0);
      check_valids("fill2_valids", 3'b001);
      check("fill2_data", out_data, 32'h1);
      drive(1'b1, 2'd1, 32'h3);
      out2_ready = 1'b1;
      tick();
      check("hol_level", 32'(fifo_level), 32'd2);
      check_valids("hol_valids", 3'b001);
      check("hol_data", out_data, 32'h1);
      out0_ready = 1'b1;
      out2_ready = 1'b0;
      tick();
      check("full_pop_level", 32'(fifo_level), 32'd1);
      check_valids("full_pop_valids", 3'b100);
      check("full_pop_data", out_data, 32'h2);
      check("full_pop_ready", 32'(in_ready), 32'd1);
      out0_ready = 1'b0;
      out2_ready = 1'b1;
      tick();
      drive(1'b0, 2'd0, 32'h0);
      check("pushpop_level", 32'(fifo_level), 32'd1);
      check_valids("pushpop_valids", 3'b010);
      check("pushpop_data", out_data, 32'h3);
      out2_ready = 1'b0;
      out1_ready = 1'b1;
      tick();
      check("drain_level", 32'(fifo_level), 32'd0);
      check_valids("drain_valids", 3'b000);
      out1_ready = 1'b0;

      // Illegal select
      drive(1'b1, 2'd3, 32'h55);
      tick();
      drive(1'b0, 2'd0, 32'h0);
      check("ill_err", 32'(err_sel), 32'd1);
      check_valids("ill_valids", 3'b000);
      check("ill_level", 32'(fifo_level), 32'd0);
`ifdef DEMUX32_DROP_CNT_EN
      check("ill_drop1", 32'(drop_cnt), 32'd1);
`endif
      tick();
      check("ill_err_clear", 32'(err_sel), 32'd0);
`ifdef DEMUX32_DROP_CNT_EN
      drive(1'b1, 2'd3, 32'h55);
      repeat (300) tick();
      drive(1'b0, 2'd0, 32'h0);
      check("ill_drop_sat", 32'(drop_cnt), 32'd255);
      tick();
`endif

      // Illegal accept concurrent with a pop
      out0_ready = 1'b0;
      drive(1'b1, 2'd0, 32'h77);
      tick();
      out0_ready = 1'b1;
      drive(1'b1, 2'd3, 32'h99);
      tick();
      drive(1'b0, 2'd0, 32'h0);
      check("illpop_err", 32'(err_sel), 32'd1);
      check("illpop_level", 32'(fifo_level), 32'd0);
      tick();
      check("illpop_err_clear", 32'(err_sel), 32'd0);

      // Back-to-back stream, alternating destinations 0 and 2
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      out2_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, (i % 2 == 1) ? 2'd2 : 2'd0, 32'h100 + 32'(i));
         tick();
         check($sformatf("stream_data_%0d", i), out_data, 32'h100 + 32'(i));
         check_valids($sformatf("stream_valids_%0d", i), (i % 2 == 1) ? 3'b100 : 3'b001);
         check($sformatf("stream_level_%0d", i), 32'(fifo_level), 32'd1);
      end
      drive(1'b0, 2'd0, 32'h0);
      tick();
      check("stream_end_level", 32'(fifo_level), 32'd0);

      // Asynchronous reset with buffered words
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      out2_ready = 1'b0;
      drive(1'b1, 2'd2, 32'hA);
      tick();
      drive(1'b1, 2'd2, 32'hB);
      tick();
      drive(1'b0, 2'd0, 32'h0);
      check("prerst_level", 32'(fifo_level), 32'd2);
      check_valids("prerst_valids", 3'b100);
      #2 reset = 1'b1;
      #1;
      check_valids("arst_valids", 3'b000);
      check("arst_level", 32'(fifo_level), 32'd0);
      check("arst_data", out_data, 32'd0);
      #1 reset = 1'b0;
      out0_ready = 1'b1;
      drive(1'b1, 2'd0, 32'hC0FFEE);
      tick();
      drive(1'b0, 2'd0, 32'h0);
      check_valids("postrst_valids", 3'b001);
      check("postrst_data", out_data, 32'hC0FFEE);
      tick();
      check("postrst_level", 32'(fifo_level), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
